// File: rtl/fu_sch.sv
// Age-ordered issue scheduler: picks the oldest ready entries for the mult, two ALU and
// address units each cycle, tracks multiplier occupancy and returns wait-clear bits.
module fu_sch #(
  parameter int unsigned ISQ_DEPTH        = 64,
  parameter int unsigned ISQ_IDX_BITS_NUM = 6,
  parameter int unsigned MUL_LAT          = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ISQ_DEPTH-1:0]        req_mul,
  input  logic [ISQ_DEPTH-1:0]        req_alu,
  input  logic [ISQ_DEPTH-1:0]        req_adr,
  input  logic [ISQ_IDX_BITS_NUM-1:0] head_idx,
  input  logic                        fls,
  input  logic [3:0]                  fun_rdy_frm_exe,
  output logic                        gnt_mul_vld,
  output logic [ISQ_IDX_BITS_NUM-1:0] gnt_mul_idx,
  output logic                        gnt_alu1_vld,
  output logic [ISQ_IDX_BITS_NUM-1:0] gnt_alu1_idx,
  output logic                        gnt_alu2_vld,
  output logic [ISQ_IDX_BITS_NUM-1:0] gnt_alu2_idx,
  output logic                        gnt_adr_vld,
  output logic [ISQ_IDX_BITS_NUM-1:0] gnt_adr_idx,
  output logic [ISQ_DEPTH-1:0]        clr_inst_wat,
  output logic                        mul_bsy
);

  localparam int unsigned IW    = ISQ_IDX_BITS_NUM;
  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  // Lowest set bit of v; MSB of the result flags a hit.
  function automatic logic [IW:0] find_first(input logic [ISQ_DEPTH-1:0] v);
    find_first = '0;
    for (int i = ISQ_DEPTH - 1; i >= 0; i--) begin
      if (v[i]) find_first = {1'b1, IW'(i)};
    end
  endfunction

  // Rotate so that bit 0 is the head entry; lowest set bit is then the oldest.
  function automatic logic [ISQ_DEPTH-1:0] age_rot(input logic [ISQ_DEPTH-1:0] v,
                                                   input logic [IW-1:0] head);
    logic [2*ISQ_DEPTH-1:0] dbl;
    dbl = {v, v} >> head;
    age_rot = dbl[ISQ_DEPTH-1:0];
  endfunction

  logic                 mul_vld_q, alu1_vld_q, alu2_vld_q, adr_vld_q, bsy_q;
  logic                 mul_vld_d, alu1_vld_d, alu2_vld_d, adr_vld_d, bsy_d;
  logic [IW-1:0]        mul_idx_q, alu1_idx_q, alu2_idx_q, adr_idx_q;
  logic [IW-1:0]        mul_idx_d, alu1_idx_d, alu2_idx_d, adr_idx_d;
  logic [ISQ_DEPTH-1:0] clr_q, clr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [ISQ_DEPTH-1:0] m_mul, m_adr, m_alu, rot_alu;
  logic [IW:0]          ff_mul, ff_adr, ff_alu_a, ff_alu_b;

  // Mask last cycle's grants, then apply per-entry type priority mul > adr > alu.
  always_comb begin
    m_mul    = req_mul & ~clr_q;
    m_adr    = req_adr & ~clr_q & ~req_mul;
    m_alu    = req_alu & ~clr_q & ~req_mul & ~req_adr;
    rot_alu  = age_rot(m_alu, head_idx);
    ff_mul   = find_first(age_rot(m_mul, head_idx));
    ff_adr   = find_first(age_rot(m_adr, head_idx));
    ff_alu_a = find_first(rot_alu);
    ff_alu_b = find_first(rot_alu & (rot_alu - ISQ_DEPTH'(1)));
  end

  always_comb begin
    mul_vld_d  = 1'b0;
    alu1_vld_d = 1'b0;
    alu2_vld_d = 1'b0;
    adr_vld_d  = 1'b0;
    mul_idx_d  = '0;
    alu1_idx_d = '0;
    alu2_idx_d = '0;
    adr_idx_d  = '0;
    clr_d      = '0;
    cnt_d      = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    bsy_d      = (cnt_q != '0);
    if (fls) begin
      cnt_d = '0;
      bsy_d = 1'b0;
    end else begin
      if (ff_mul[IW] && (cnt_q == '0) && fun_rdy_frm_exe[0]) begin
        mul_vld_d = 1'b1;
        mul_idx_d = IW'(head_idx + ff_mul[IW-1:0]);
        cnt_d     = CNT_W'(MUL_LAT - 1);
      end
      if (ff_adr[IW] && fun_rdy_frm_exe[3]) begin
        adr_vld_d = 1'b1;
        adr_idx_d = IW'(head_idx + ff_adr[IW-1:0]);
      end
      // Oldest ALU op goes to alu1 when it is ready, otherwise to alu2.
      if (ff_alu_a[IW]) begin
        if (fun_rdy_frm_exe[1]) begin
          alu1_vld_d = 1'b1;
          alu1_idx_d = IW'(head_idx + ff_alu_a[IW-1:0]);
          if (fun_rdy_frm_exe[2] && ff_alu_b[IW]) begin
            alu2_vld_d = 1'b1;
            alu2_idx_d = IW'(head_idx + ff_alu_b[IW-1:0]);
          end
        end else if (fun_rdy_frm_exe[2]) begin
          alu2_vld_d = 1'b1;
          alu2_idx_d = IW'(head_idx + ff_alu_a[IW-1:0]);
        end
      end
      if (mul_vld_d)  clr_d = clr_d | (ISQ_DEPTH'(1) << mul_idx_d);
      if (adr_vld_d)  clr_d = clr_d | (ISQ_DEPTH'(1) << adr_idx_d);
      if (alu1_vld_d) clr_d = clr_d | (ISQ_DEPTH'(1) << alu1_idx_d);
      if (alu2_vld_d) clr_d = clr_d | (ISQ_DEPTH'(1) << alu2_idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_vld_q  <= 1'b0;
      alu1_vld_q <= 1'b0;
      alu2_vld_q <= 1'b0;
      adr_vld_q  <= 1'b0;
      mul_idx_q  <= '0;
      alu1_idx_q <= '0;
      alu2_idx_q <= '0;
      adr_idx_q  <= '0;
      clr_q      <= '0;
      cnt_q      <= '0;
      bsy_q      <= 1'b0;
    end else begin
      mul_vld_q  <= mul_vld_d;
      alu1_vld_q <= alu1_vld_d;
      alu2_vld_q <= alu2_vld_d;
      adr_vld_q  <= adr_vld_d;
      mul_idx_q  <= mul_idx_d;
      alu1_idx_q <= alu1_idx_d;
      alu2_idx_q <= alu2_idx_d;
      adr_idx_q  <= adr_idx_d;
      clr_q      <= clr_d;
      cnt_q      <= cnt_d;
      bsy_q      <= bsy_d;
    end
  end

  assign gnt_mul_vld  = mul_vld_q;
  assign gnt_mul_idx  = mul_idx_q;
  assign gnt_alu1_vld = alu1_vld_q;
  assign gnt_alu1_idx = alu1_idx_q;
  assign gnt_alu2_vld = alu2_vld_q;
  assign gnt_alu2_idx = alu2_idx_q;
  assign gnt_adr_vld  = adr_vld_q;
  assign gnt_adr_idx  = adr_idx_q;
  assign clr_inst_wat = clr_q;
  assign mul_bsy      = bsy_q;

endmodule

// File: tb/tb_fu_sch.sv
// Directed bench for fu_sch with hand-computed expected grants.
module tb_fu_sch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] req_mul, req_alu, req_adr;
  logic [5:0]  head_idx;
  logic        fls;
  logic [3:0]  rdy;
  logic        gnt_mul_vld, gnt_alu1_vld, gnt_alu2_vld, gnt_adr_vld;
  logic [5:0]  gnt_mul_idx, gnt_alu1_idx, gnt_alu2_idx, gnt_adr_idx;
  logic [63:0] clr_inst_wat;
  logic        mul_bsy;

  int checks = 0;
  int failures = 0;

  fu_sch #(.ISQ_DEPTH(64), .ISQ_IDX_BITS_NUM(6), .MUL_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_mul(req_mul), .req_alu(req_alu), .req_adr(req_adr),
    .head_idx(head_idx), .fls(fls), .fun_rdy_frm_exe(rdy),
    .gnt_mul_vld(gnt_mul_vld), .gnt_mul_idx(gnt_mul_idx),
    .gnt_alu1_vld(gnt_alu1_vld), .gnt_alu1_idx(gnt_alu1_idx),
    .gnt_alu2_vld(gnt_alu2_vld), .gnt_alu2_idx(gnt_alu2_idx),
    .gnt_adr_vld(gnt_adr_vld), .gnt_adr_idx(gnt_adr_idx),
    .clr_inst_wat(clr_inst_wat), .mul_bsy(mul_bsy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_mul = '0; req_alu = '0; req_adr = '0;
    head_idx = '0; fls = 1'b0; rdy = 4'b1111;
    rst_n = 1'b0;
    step();
    check("rst_vld", 64'({gnt_mul_vld, gnt_alu1_vld, gnt_alu2_vld, gnt_adr_vld}), 64'd0);
    check("rst_idx", 64'({gnt_mul_idx, gnt_alu1_idx, gnt_alu2_idx, gnt_adr_idx}), 64'd0);
    check("rst_clr", clr_inst_wat, 64'd0);
    check("rst_bsy", 64'(mul_bsy), 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic chk_alu(input string tag, input logic v1, input logic [5:0] i1,
                         input logic v2, input logic [5:0] i2);
    check({tag, "_a1v"}, 64'(gnt_alu1_vld), 64'(v1));
    check({tag, "_a1i"}, 64'(gnt_alu1_idx), 64'(i1));
    check({tag, "_a2v"}, 64'(gnt_alu2_vld), 64'(v2));
    check({tag, "_a2i"}, 64'(gnt_alu2_idx), 64'(i2));
  endtask

  initial begin
    // Two ALU ops, then double-grant mask
    do_reset();
    req_alu = (64'd1 << 5) | (64'd1 << 9);
    step();
    chk_alu("t1", 1'b1, 6'd5, 1'b1, 6'd9);
    check("t1_clr", clr_inst_wat, (64'd1 << 5) | (64'd1 << 9));
    check("t1_mulv", 64'(gnt_mul_vld), 64'd0);
    step();
    chk_alu("t1m", 1'b0, 6'd0, 1'b0, 6'd0);
    check("t1m_clr", clr_inst_wat, 64'd0);

    // Age wrap from 63 to 0
    do_reset();
    head_idx = 6'd60;
    req_alu = (64'd1 << 2) | (64'd1 << 62);
    step();
    chk_alu("t2", 1'b1, 6'd62, 1'b1, 6'd2);

    // Oldest relative to mid-queue head
    do_reset();
    head_idx = 6'd10;
    req_alu = (64'd1 << 5) | (64'd1 << 15) | (64'd1 << 40);
    step();
    chk_alu("t9", 1'b1, 6'd15, 1'b1, 6'd40);

    // Multiplier occupancy spacing and busy flag
    do_reset();
    req_mul = (64'd1 << 7) | (64'd1 << 8);
    step();
    check("t3_c1v", 64'(gnt_mul_vld), 64'd1);
    check("t3_c1i", 64'(gnt_mul_idx), 64'd7);
    check("t3_c1b", 64'(mul_bsy), 64'd0);
    req_mul = 64'd1 << 8;
    step();
    check("t3_c2v", 64'(gnt_mul_vld), 64'd0);
    check("t3_c2b", 64'(mul_bsy), 64'd1);
    step();
    check("t3_c3v", 64'(gnt_mul_vld), 64'd0);
    check("t3_c3b", 64'(mul_bsy), 64'd1);
    step();
    check("t3_c4v", 64'(gnt_mul_vld), 64'd1);
    check("t3_c4i", 64'(gnt_mul_idx), 64'd8);
    check("t3_c4b", 64'(mul_bsy), 64'd0);
    req_mul = '0;
    step();
    check("t3_c5b", 64'(mul_bsy), 64'd1);
    step();
    check("t3_c6b", 64'(mul_bsy), 64'd1);
    step();
    check("t3_c7b", 64'(mul_bsy), 64'd0);

    // Partial function-ready
    do_reset();
    rdy = 4'b0100;
    req_alu = (64'd1 << 3) | (64'd1 << 4);
    step();
    chk_alu("t4", 1'b0, 6'd0, 1'b1, 6'd3);
    rdy = 4'b0000;
    step();
    chk_alu("t4n", 1'b0, 6'd0, 1'b0, 6'd0);
    check("t4n_clr", clr_inst_wat, 64'd0);

    // Type priority mul over alu
    do_reset();
    req_mul = 64'd1 << 10;
    req_alu = (64'd1 << 10) | (64'd1 << 11);
    step();
    check("t5_mulv", 64'(gnt_mul_vld), 64'd1);
    check("t5_muli", 64'(gnt_mul_idx), 64'd10);
    chk_alu("t5", 1'b1, 6'd11, 1'b0, 6'd0);
    check("t5_clr", clr_inst_wat, (64'd1 << 10) | (64'd1 << 11));

    // Address unit, adr over alu, and rdy[3] gating
    do_reset();
    req_adr = (64'd1 << 20) | (64'd1 << 21);
    req_alu = (64'd1 << 20) | (64'd1 << 30);
    step();
    check("t7_adrv", 64'(gnt_adr_vld), 64'd1);
    check("t7_adri", 64'(gnt_adr_idx), 64'd20);
    chk_alu("t7", 1'b1, 6'd30, 1'b0, 6'd0);
    rdy = 4'b0111;
    req_adr = 64'd1 << 22;
    req_alu = '0;
    step();
    check("t7g_adrv", 64'(gnt_adr_vld), 64'd0);

    // Mult gated by rdy[0]
    do_reset();
    rdy = 4'b1110;
    req_mul = 64'd1 << 3;
    step();
    check("t8_mulv", 64'(gnt_mul_vld), 64'd0);
    check("t8_bsy", 64'(mul_bsy), 64'd0);

    // Flush during multiplier occupancy
    do_reset();
    req_mul = 64'd1 << 7;
    step();
    check("t6_mulv", 64'(gnt_mul_vld), 64'd1);
    req_mul = '0;
    req_alu = 64'd1 << 1;
    fls = 1'b1;
    step();
    check("t6f_vld", 64'({gnt_mul_vld, gnt_alu1_vld, gnt_alu2_vld, gnt_adr_vld}), 64'd0);
    check("t6f_bsy", 64'(mul_bsy), 64'd0);
    check("t6f_clr", clr_inst_wat, 64'd0);
    fls = 1'b0;
    req_alu = '0;
    req_mul = 64'd1 << 12;
    step();
    check("t6r_mulv", 64'(gnt_mul_vld), 64'd1);
    check("t6r_muli", 64'(gnt_mul_idx), 64'd12);

    // Reset mid occupancy clears the counter
    do_reset();
    req_mul = 64'd1 << 1;
    step();
    check("t10_mulv", 64'(gnt_mul_vld), 64'd1);
    do_reset();
    req_mul = 64'd1 << 1;
    step();
    check("t10r_mulv", 64'(gnt_mul_vld), 64'd1);
    check("t10r_muli", 64'(gnt_mul_idx), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
